code_checker: RTL

CODE_CHECKER -- requirements
Module: code_checker

---
 rtl/code_checker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/code_checker.sv
// -----------------------------------------------------------------------------
// code_checker
//
// Compares a four-digit code (2 bits per digit) captured from the button-entry
// stage against a stored secret. Each digit is compared over a fixed step time,
// so the time spent comparing is set by the position of the first wrong digit
// (EARLY_EXIT=1) or is the same for every attempt (EARLY_EXIT=0). The verdict is
// then displayed on unlock/fail for a fixed hold time. After that, restart
// re-arms the entry stage, and the checker waits for done to drop before it
// accepts another attempt.
//
// Parameters
//   SECRET             stored code, digit i at bits [2i+1:2i]
//   STEP_DELAY_CYCLES  compare time per digit in clk cycles (>= 1)
//   RESULT_HOLD_CYCLES cycles that unlock/fail are displayed (>= 1)
//   EARLY_EXIT         1: stop at first wrong digit, 0: constant-time compare
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   done           level from the entry stage: the code entry is complete
//   code           entered digits, digit i at [2i+1:2i]
//   restart        one-cycle pulse, high only in RELEASE
//   busy           high in every state except IDLE
//   unlock         high for the whole result hold after a match
//   fail           high for the whole result hold after a mismatch
//   compare_cycles cycles spent in COMPARE on the last attempt (saturating)
//   attempts       completed compares, saturating at 255
//   state_dbg      current FSM state encoding, for observation only
//
// Handshake: done is a level, not a pulse. It is sampled only in IDLE. Once an
// attempt has started, done is ignored until WAIT_CLEAR, and WAIT_CLEAR
// requires done to go low. This stops a done that is still held high from
// starting a second attempt.
// -----------------------------------------------------------------------------
module code_checker #(
  parameter logic [7:0] SECRET             = 8'b10_01_00_10,
  parameter int         STEP_DELAY_CYCLES  = 100_000,
  parameter int         RESULT_HOLD_CYCLES = 200_000_000,
  parameter int         EARLY_EXIT         = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic [7:0]  code,
  output logic        restart,
  output logic        busy,
  output logic        unlock,
  output logic        fail,
  output logic [31:0] compare_cycles,
  output logic [7:0]  attempts,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    RESULT     = 3'd2,
    RELEASE    = 3'd3,
    WAIT_CLEAR = 3'd4
  } state_t;

  // Counters are sized to hold (limit - 1). A limit of 1 still gets a
  // 1-bit counter, so the widths never collapse to zero.
  localparam int STEP_W = (STEP_DELAY_CYCLES > 1) ? $clog2(STEP_DELAY_CYCLES) : 1;
  localparam int HOLD_W = (RESULT_HOLD_CYCLES > 1) ? $clog2(RESULT_HOLD_CYCLES) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DELAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_HOLD_CYCLES - 1);
  localparam logic [7:0]        SECRET_C  = SECRET;
  localparam bit                EARLY_C   = (EARLY_EXIT != 0);

  state_t              state;
  logic [7:0]          code_q;     // code captured when the attempt starts
  logic [1:0]          digit_idx;  // digit currently being compared
  logic [STEP_W-1:0]   step_cnt;   // cycle within the current digit's step
  logic [HOLD_W-1:0]   hold_cnt;   // cycle within the result hold
  logic                mismatch;   // sticky: some digit so far was wrong
  logic [31:0]         cyc_cnt;    // COMPARE cycles so far, counting the current one

  // Next-state helpers
  logic [1:0]  cur_digit;
  logic [1:0]  ref_digit;
  logic        digit_bad;
  logic        mismatch_next;
  logic        step_last;
  logic        hold_last;
  logic        compare_exit;
  logic [31:0] cyc_inc;
  logic [7:0]  attempts_inc;

  always_comb begin
    cur_digit     = code_q[{digit_idx, 1'b0} +: 2];
    ref_digit     = SECRET_C[{digit_idx, 1'b0} +: 2];
    digit_bad     = (cur_digit != ref_digit);
    mismatch_next = mismatch | digit_bad;
    step_last     = (step_cnt == STEP_LAST);
    hold_last     = (hold_cnt == HOLD_LAST);
    // A digit is judged only on the last cycle of its step. The attempt ends
    // after the last digit, or earlier on the first wrong digit when
    // early exit is enabled.
    compare_exit  = step_last && ((EARLY_C && digit_bad) || (digit_idx == 2'd3));
    cyc_inc       = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;
    attempts_inc  = (attempts == 8'hFF) ? attempts : attempts + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      code_q         <= 8'd0;
      digit_idx      <= 2'd0;
      step_cnt       <= '0;
      hold_cnt       <= '0;
      mismatch       <= 1'b0;
      cyc_cnt        <= 32'd0;
      restart        <= 1'b0;
      busy           <= 1'b0;
      unlock         <= 1'b0;
      fail           <= 1'b0;
      compare_cycles <= 32'd0;
      attempts       <= 8'd0;
    end else begin
      // restart is a one-cycle pulse. It is set only on the transition into
      // RELEASE and cleared on every other cycle.
      restart <= 1'b0;

      case (state)
        IDLE: begin
          if (done) begin
            code_q    <= code;
            digit_idx <= 2'd0;
            step_cnt  <= '0;
            mismatch  <= 1'b0;
            // The first COMPARE cycle is already counted here, so at exit
            // cyc_cnt equals the number of cycles spent in COMPARE.
            cyc_cnt   <= 32'd1;
            busy      <= 1'b1;
            state     <= COMPARE;
          end
        end

        COMPARE: begin
          if (compare_exit) begin
            mismatch       <= mismatch_next;
            unlock         <= ~mismatch_next;
            fail           <= mismatch_next;
            hold_cnt       <= '0;
            compare_cycles <= cyc_cnt;
            attempts       <= attempts_inc;
            state          <= RESULT;
          end else if (step_last) begin
            mismatch  <= mismatch_next;
            digit_idx <= digit_idx + 2'd1;
            step_cnt  <= '0;
            cyc_cnt   <= cyc_inc;
          end else begin
            step_cnt <= step_cnt + 1'b1;
            cyc_cnt  <= cyc_inc;
          end
        end

        RESULT: begin
          if (hold_last) begin
            unlock  <= 1'b0;
            fail    <= 1'b0;
            restart <= 1'b1;
            state   <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RELEASE: begin
          state <= WAIT_CLEAR;
        end

        WAIT_CLEAR: begin
          if (!done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          unlock <= 1'b0;
          fail   <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
